vmx_dma_cmd_splitter: RTL

Converts one DMA descriptor (word-aligned base address, length in 32-bit words, direction) into a sequence of AXI burst commands. It pushes them into the command FIFO that feeds the VMX engine's M_AXI DMA master. It sits directly upstream of that FIFO, between the engine's descriptor source and the DMA master. Each burst is capped at MAX_BURST beats and, when configured, never crosses a 4 KB boundary.

---
 rtl/vmx_dma_pkg.sv | 41 ++++
 rtl/vmx_burst_calc.sv | 50 +++++
 rtl/vmx_dma_cmd_splitter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vmx_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vmx_dma_pkg
// Brief    : Shared command layout, FSM encoding and helpers for the VMX DMA
//            command path.
// Revision : 1.0 - initial release
// ============================================================================
package vmx_dma_pkg;

  localparam int CMD_W         = 41;
  localparam int CMD_DIR_BIT   = 40;
  localparam int CMD_LEN_MSB   = 39;
  localparam int CMD_LEN_LSB   = 32;
  localparam int CMD_ADDR_MSB  = 31;
  localparam int CMD_ADDR_LSB  = 0;

  // Beat count register width: holds 1..256.
  localparam int BEAT_W        = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_PUSH = 2'd2,
    ST_DONE = 2'd3
  } vmx_cmd_state_t;

  function automatic logic [CMD_W-1:0] build_cmd(
    input logic        dir,
    input logic [7:0]  axlen,
    input logic [31:0] addr
  );
    logic [CMD_W-1:0] cmd;
    cmd                             = '0;
    cmd[CMD_DIR_BIT]                = dir;
    cmd[CMD_LEN_MSB:CMD_LEN_LSB]    = axlen;
    cmd[CMD_ADDR_MSB:CMD_ADDR_LSB]  = addr;
    return cmd;
  endfunction

endpackage : vmx_dma_pkg
`default_nettype wire

// File: rtl/vmx_burst_calc.sv
`default_nettype none
// ============================================================================
// Module   : vmx_burst_calc
// Brief    : Combinational beat count = min(remaining, MAX_BURST[, words_to_4k]).
//            4 KB clipping enabled by macro VMX_CMD_4K_SPLIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vmx_burst_calc
  import vmx_dma_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 24
) (
  input  logic [LEN_W-1:0]  i_remaining,
  input  logic [11:0]       i_addr_lo,
  output logic [BEAT_W-1:0] o_beats
);

  localparam int CALC_W = (LEN_W > 11) ? LEN_W : 11;
  localparam logic [CALC_W-1:0] C_MAX_BURST = CALC_W'(MAX_BURST);

  logic [CALC_W-1:0] w_rem;
  logic [CALC_W-1:0] w_lim_burst;
  logic [CALC_W-1:0] w_lim;
  logic              w_unused_hi;
  logic              w_unused_addr;

  assign w_rem       = CALC_W'(i_remaining);
  assign w_lim_burst = (w_rem < C_MAX_BURST) ? w_rem : C_MAX_BURST;

`ifdef VMX_CMD_4K_SPLIT_EN
  logic [10:0]       w_words_to_4k;
  logic [CALC_W-1:0] w_words_to_4k_ext;

  // Word index within the 4 KB page; distance to the next page is 1..1024.
  assign w_words_to_4k     = 11'd1024 - {1'b0, i_addr_lo[11:2]};
  assign w_words_to_4k_ext = CALC_W'(w_words_to_4k);
  assign w_lim             = (w_lim_burst < w_words_to_4k_ext) ? w_lim_burst : w_words_to_4k_ext;
  assign w_unused_addr     = ^i_addr_lo[1:0];
`else
  assign w_lim             = w_lim_burst;
  assign w_unused_addr     = ^i_addr_lo;
`endif

  // Result never exceeds 256, so the upper bits are always zero.
  assign o_beats     = w_lim[BEAT_W-1:0];
  assign w_unused_hi = |w_lim[CALC_W-1:BEAT_W];

endmodule : vmx_burst_calc
`default_nettype wire

// File: rtl/vmx_dma_cmd_splitter.sv
`default_nettype none
// ============================================================================
// Module   : vmx_dma_cmd_splitter
// Brief    : Splits a DMA descriptor into AXI burst commands for the M_AXI
//            command FIFO. Optional 4 KB clipping: VMX_CMD_4K_SPLIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vmx_dma_cmd_splitter
  import vmx_dma_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 24
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESETN,
  input  logic              DESC_VALID,
  output logic              DESC_READY,
  input  logic [31:0]       DESC_ADDR,
  input  logic [LEN_W-1:0]  DESC_LEN,
  input  logic              DESC_WRITE,
  output logic [CMD_W-1:0]  CMD_FIFO_DATA,
  output logic              CMD_FIFO_WREN,
  input  logic              CMD_FIFO_FULL,
  output logic              BUSY,
  output logic              DESC_DONE
);

  vmx_cmd_state_t    r_state;
  vmx_cmd_state_t    w_state_nxt;

  logic [31:0]       r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_dir;
  logic [BEAT_W-1:0] r_beats;

  logic [BEAT_W-1:0] w_beats;
  logic [LEN_W-1:0]  w_beats_ext;
  logic [7:0]        w_axlen;
  logic              w_load;
  logic              w_calc;
  logic              w_push;
  logic              w_wren_nxt;
  logic              w_done_nxt;

  vmx_burst_calc #(
    .MAX_BURST (MAX_BURST),
    .LEN_W     (LEN_W)
  ) u_burst_calc (
    .i_remaining (r_remaining),
    .i_addr_lo   (r_addr[11:0]),
    .o_beats     (w_beats)
  );

  assign w_beats_ext = LEN_W'(r_beats);
  // A 256-beat burst wraps to AxLEN 8'hFF, which is the intended encoding.
  assign w_axlen     = w_beats[7:0] - 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_calc      = 1'b0;
    w_push      = 1'b0;
    w_wren_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (DESC_VALID) begin
          w_load      = 1'b1;
          w_state_nxt = (DESC_LEN == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        w_calc      = 1'b1;
        w_state_nxt = ST_PUSH;
      end
      ST_PUSH: begin
        if (!CMD_FIFO_FULL) begin
          w_push      = 1'b1;
          w_wren_nxt  = 1'b1;
          w_state_nxt = (r_remaining == w_beats_ext) ? ST_DONE : ST_CALC;
        end
      end
      ST_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs track the next state so they line up with r_state.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state       <= ST_IDLE;
      DESC_READY    <= 1'b1;
      BUSY          <= 1'b0;
      CMD_FIFO_WREN <= 1'b0;
      DESC_DONE     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      DESC_READY    <= (w_state_nxt == ST_IDLE);
      BUSY          <= (w_state_nxt != ST_IDLE);
      CMD_FIFO_WREN <= w_wren_nxt;
      DESC_DONE     <= w_done_nxt;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_addr        <= '0;
      r_remaining   <= '0;
      r_dir         <= 1'b0;
      r_beats       <= '0;
      CMD_FIFO_DATA <= '0;
    end else begin
      if (w_load) begin
        r_addr      <= DESC_ADDR & 32'hFFFF_FFFC;
        r_remaining <= DESC_LEN;
        r_dir       <= DESC_WRITE;
      end
      if (w_calc) begin
        r_beats       <= w_beats;
        CMD_FIFO_DATA <= build_cmd(r_dir, w_axlen, r_addr);
      end
      // Address wraps silently at 2^32; beats <= remaining so no underflow.
      if (w_push) begin
        r_addr      <= r_addr + {21'd0, r_beats, 2'b00};
        r_remaining <= r_remaining - w_beats_ext;
      end
    end
  end

endmodule : vmx_dma_cmd_splitter
`default_nettype wire
